// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Shared seven-segment definitions: bit order, hex glyph
//               constants and the blank pattern (logical polarity, lit = 1).
// Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // Segment vector bit order, MSB..LSB: {g, f, e, d, c, b, a}
    localparam int SEG_W     = 7;
    localparam int SEG_BIT_A = 0;
    localparam int SEG_BIT_B = 1;
    localparam int SEG_BIT_C = 2;
    localparam int SEG_BIT_D = 3;
    localparam int SEG_BIT_E = 4;
    localparam int SEG_BIT_F = 5;
    localparam int SEG_BIT_G = 6;

    typedef logic [SEG_W-1:0] seg_t;

    // Hex glyphs, logical polarity (1 = segment lit)
    localparam seg_t SEG_0   = 7'h3F;
    localparam seg_t SEG_1   = 7'h06;
    localparam seg_t SEG_2   = 7'h5B;
    localparam seg_t SEG_3   = 7'h4F;
    localparam seg_t SEG_4   = 7'h66;
    localparam seg_t SEG_5   = 7'h6D;
    localparam seg_t SEG_6   = 7'h7D;
    localparam seg_t SEG_7   = 7'h07;
    localparam seg_t SEG_8   = 7'h7F;
    localparam seg_t SEG_9   = 7'h6F;
    localparam seg_t SEG_A   = 7'h77;
    localparam seg_t SEG_B   = 7'h7C;
    localparam seg_t SEG_C   = 7'h39;
    localparam seg_t SEG_D   = 7'h5E;
    localparam seg_t SEG_E   = 7'h79;
    localparam seg_t SEG_F   = 7'h71;
    localparam seg_t SEG_OFF = 7'h00;

endpackage : seg7_pkg
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decode
// Description : Combinational 4-bit nibble to 7-bit logical segment decoder.
//               The single home of the hex glyph table.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    // Full 16-entry hex lookup
    always_comb begin
        o_seg = SEG_OFF;
        case (i_nibble)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule : seg7_hex_decode
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed N-digit seven-segment driver with tear-free
//               frame shadowing, leading-zero blanking, per-digit decimal
//               points and selectable output polarity.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int CLK_DIV    = 100000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  iClk,
    input  logic                  iRst,
    input  logic                  iEn,
    input  logic [4*DIGITS-1:0]   iData,
    input  logic [DIGITS-1:0]     iDp,
    input  logic                  iBlankLz,
    output logic [SEG_W-1:0]      oSeg,
    output logic                  oDp,
    output logic [DIGITS-1:0]     oAn
);

    localparam int C_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int C_IDX_W = (DIGITS  > 1) ? $clog2(DIGITS)  : 1;

    localparam logic [C_DIV_W-1:0] C_DIV_LAST   = C_DIV_W'(CLK_DIV - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_LAST   = C_IDX_W'(DIGITS - 1);
    localparam seg_t               C_SEG_IDLE   = SEG_OFF ^ {SEG_W{ACTIVE_LOW}};
    localparam logic [DIGITS-1:0]  C_AN_IDLE    = {DIGITS{ACTIVE_LOW}};

    logic [C_DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [C_IDX_W-1:0]    idx_q,     idx_d;
    logic [4*DIGITS-1:0]   sh_data_q, sh_data_d;
    logic [DIGITS-1:0]     sh_dp_q,   sh_dp_d;
    seg_t                  seg_q,     seg_d;
    logic                  dp_q,      dp_d;
    logic [DIGITS-1:0]     an_q,      an_d;

    logic                  w_tick;
    logic                  w_load;
    logic [3:0]            w_cur_nibble;
    logic                  w_cur_dp;
    logic                  w_upper_nonzero;
    logic                  w_blank;
    logic                  w_lit;
    seg_t                  w_dec_seg;

    // Prescaler, digit index, frame shadow and current-digit selection.
    // sh_data_d already equals iData on a load cycle, so it doubles as the
    // bypass path that lets the first digit of a frame show fresh input.
    always_comb begin
        w_tick    = (div_cnt_q == C_DIV_LAST);
        w_load    = (idx_q == '0) && (div_cnt_q == '0);
        div_cnt_d = w_tick ? '0 : div_cnt_q + C_DIV_W'(1);
        idx_d     = idx_q;
        if (w_tick) begin
            idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + C_IDX_W'(1);
        end
        sh_data_d = w_load ? iData : sh_data_q;
        sh_dp_d   = w_load ? iDp   : sh_dp_q;

        w_cur_nibble    = 4'h0;
        w_cur_dp        = 1'b0;
        w_upper_nonzero = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (C_IDX_W'(k) == idx_q) begin
                w_cur_nibble = sh_data_d[4*k +: 4];
                w_cur_dp     = sh_dp_d[k];
            end
            if ((C_IDX_W'(k) >= idx_q) && (sh_data_d[4*k +: 4] != 4'h0)) begin
                w_upper_nonzero = 1'b1;
            end
        end
    end

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_cur_nibble),
        .o_seg    (w_dec_seg)
    );

    // Blanking, enable gating and polarity applied ahead of the output flops
    always_comb begin
        w_blank = iBlankLz && (idx_q != '0) && !w_upper_nonzero && !w_cur_dp;
        w_lit   = iEn && !w_blank;
        seg_d   = (w_lit ? w_dec_seg : SEG_OFF) ^ {SEG_W{ACTIVE_LOW}};
        dp_d    = (w_lit && w_cur_dp) ^ ACTIVE_LOW;
        an_d    = C_AN_IDLE;
        for (int k = 0; k < DIGITS; k++) begin
            if (iEn && (C_IDX_W'(k) == idx_q)) begin
                an_d[k] = ~ACTIVE_LOW;
            end
        end
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            div_cnt_q <= '0;
            idx_q     <= '0;
            sh_data_q <= '0;
            sh_dp_q   <= '0;
            seg_q     <= C_SEG_IDLE;
            dp_q      <= ACTIVE_LOW;
            an_q      <= C_AN_IDLE;
        end else begin
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            sh_data_q <= sh_data_d;
            sh_dp_q   <= sh_dp_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
        end
    end

    assign oSeg = seg_q;
    assign oDp  = dp_q;
    assign oAn  = an_q;

endmodule : seg7_scan_driver
`default_nettype wire

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed N-digit seven-segment display driver: the next generation of the single-digit `display7` decoder. Takes a packed hex word, refreshes one digit at a time on a common segment bus with one-hot digit enables, and supports full hex decode, per-digit decimal points, leading-zero blanking and configurable output polarity. Sits between datapath result registers and the board display pins.

## Interface

**Parameters**
- `DIGITS`, 8: number of digits, legal range 1..8.
- `CLK_DIV`, 100000: clock cycles per digit slot, legal range ≥1.
- `ACTIVE_LOW`, 1: 1 inverts `oSeg`, `oDp` and `oAn` (lit/enabled = 0); 0 means lit/enabled = 1.

**Ports**
- `iClk` in 1: the single clock.
- `iRst` in 1: reset, asynchronous and active-high.
- `iEn` in 1: display enable; 0 blanks all outputs.
- `iData` in 4*DIGITS: hex nibbles; digit k is `iData[4k+3:4k]`, digit 0 is rightmost.
- `iDp` in DIGITS: decimal point per digit.
- `iBlankLz` in 1: 1 enables leading-zero blanking.
- `oSeg` out 7: `{g,f,e,d,c,b,a}`.
- `oDp` out 1: decimal point for the current digit.
- `oAn` out DIGITS: one-hot digit enable.

## Operation

- Prescaler `div_cnt` counts 0..CLK_DIV-1 and wraps. `tick` = (div_cnt == CLK_DIV-1).
- Digit index `idx` advances on `tick`, from DIGITS-1 wrapping to 0. It holds otherwise.
- Shadow registers `sh_data`/`sh_dp` load `iData`/`iDp` when `load` = (idx==0 && div_cnt==0). Frames are therefore tear-free: the input is sampled once per full scan. On a `load` cycle the decoder takes its input from `iData`/`iDp` directly rather than from the shadow.
- Decode table, logical lit = 1:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Leading-zero blank:
  - Applies when `iBlankLz`=1.
  - Digit k is blanked (segments and dp off) if every nibble j≥k is 0 and k≠0.
  - Digit 0 is never blanked, so 0 shows as a single "0".
  - A digit whose dp is set is never blanked.
- `iEn`=0: `oAn` all disabled, `oSeg`/`oDp` off. The counters keep running.
- Polarity: the logical value is XORed with `ACTIVE_LOW` at the output register.

## Timing

- All outputs are registered and update on the cycle after the `idx`/`div_cnt` state they reflect. Latency is 1 clock from the input to the pins on a `load` cycle.
- Reset values:
  - `div_cnt`=0, `idx`=0, shadows=0.
  - `oAn` all disabled (all 1 when ACTIVE_LOW).
  - `oSeg` off, `oDp` off.
- After `iRst` falls, the first edge is a `load` cycle. At that edge `oAn` selects digit 0, showing `iData[3:0]`.
- Each digit is enabled for exactly CLK_DIV cycles. Full frame = DIGITS*CLK_DIV cycles.
- CLK_DIV=1: `tick` every cycle and `idx` advances every cycle. `load` occurs every DIGITS cycles.
- DIGITS=1: `idx` is constant 0 and `oAn` is permanently enabled while `iEn`=1.
- `iRst` asserted mid-frame: all state and outputs go to reset values immediately (asynchronous). No partial frame resumes.
- `iData` changes mid-frame are ignored until the next `load`.
- `iEn` toggles take effect at the next edge. Scan phase is unaffected.

## Structure

- Package `seg7_pkg` holds:
  - the 16-entry segment constants (`SEG_0`..`SEG_F`),
  - `SEG_OFF` = 7'h00,
  - the bit-order definition `{g..a}`.
- Sub-module `seg7_hex_decode`: combinational, 4-bit nibble to 7-bit logical segments. It is the only place the table lives.
- The top holds the prescaler, index counter, shadow registers, blanking logic and output registers.

## Test plan

- **Reset and decode, identity pattern:** DIGITS=8, CLK_DIV=4, ACTIVE_LOW=1, `iData`=32'h76543210, release reset.
  - Required: first edge gives `oAn`=8'hFE, `oSeg`=~7'h3F.
  - Required: after 4 clocks, `oAn`=8'hFD, `oSeg`=~7'h06.
  - Required: frame repeats every 32 clocks.
- **Full hex:** `iData`=32'hFEDCBA98.
  - Required: digit 2 shows ~7'h77 (A), digit 7 shows ~7'h71 (F).
  - Required: the full table matches the values in Operation.
- **Tear-free shadow:** change `iData` from 32'h11111111 to 32'h22222222 while idx=3.
  - Required: digits 3..7 still show 1 in that frame; the next frame shows all 2.
- **Leading-zero blanking:** `iBlankLz`=1, `iData`=32'h00000450, `iDp`=0.
  - Required: digits 3..7 show `oSeg`=7'h7F (off).
  - Required: `iData`=0 shows digit 0 as "0" only.
  - Required: setting `iDp`[5]=1 unblanks digit 5.
- **Enable and async reset:** `iEn`=0 gives `oAn`=8'hFF while idx keeps advancing. Pulse `iRst` mid-slot between clock edges.
  - Required: outputs go to reset values before the next edge.
  - Required: idx restarts at 0.
- **Corner parameters:** DIGITS=1, CLK_DIV=1, ACTIVE_LOW=0.
  - Required: `oAn`=1'b1 constant and `oSeg` follows `iData` with 1-cycle latency.
